// File: rtl/seg_scan_pkg.sv
// Shared types, constants and the BCD-to-segment decode for the scan controller.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        ON   = 2'd2
    } scan_state_t;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low a..g pattern (bit6 = a); non-decimal codes show nothing.
    function automatic logic [6:0] bcd_to_seg_n(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: a digit is suppressed when it and every
// digit above it are zero. Digit0 always stays visible.
module seg_lz_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] display,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   suppress
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_mask
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                // Zero-check the whole upper slice at once rather than chaining bits.
                assign suppress[gi] = blank_lz & ~(|display[4*NUM_DIGITS-1:4*gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-aligned display update,
// per-slot blank gap and optional leading-zero blanking.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic [6:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_GAP_END  = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SLOT_END = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

    scan_state_t             state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [4*NUM_DIGITS-1:0] display_reg;
    logic [4*NUM_DIGITS-1:0] pending_reg;
    logic                    pending_valid_reg;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    frame_done_next;
    logic [NUM_DIGITS-1:0]   suppress;
    logic [3:0]              digit [NUM_DIGITS];
    logic                    frame_end;
    logic                    commit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi] = display_reg[4*gi +: 4];
        end
    endgenerate

    seg_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .display  (display_reg),
        .blank_lz (blank_lz),
        .suppress (suppress)
    );

    // Last cycle of the last digit's lit phase; a disabled cycle never ends a frame.
    assign frame_end  = enable && (state_reg == ON) && (cnt_reg == CNT_SLOT_END)
                        && (idx_reg == IDX_LAST);
    assign commit     = frame_end && pending_valid_reg;
    assign load_ready = !pending_valid_reg;

    // Scan state, slot counter and digit index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state logic plus the output values the current state calls for.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        seg_next        = SEG_BLANK;
        an_next         = '1;
        frame_done_next = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = GAP;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
                GAP: begin
                    // cnt keeps running across GAP->ON; only slot changes clear it.
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_GAP_END) begin
                        state_next = ON;
                    end
                end
                ON: begin
                    if (cnt_reg == CNT_SLOT_END) begin
                        state_next = GAP;
                        cnt_next   = '0;
                        idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                    if (!suppress[idx_reg]) begin
                        an_next[idx_reg] = 1'b0;
                        seg_next         = bcd_to_seg_n(digit[idx_reg]);
                    end
                    frame_done_next = frame_end;
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Pending buffer and frame-aligned commit into the displayed word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display_reg       <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
        end else if (commit) begin
            display_reg       <= pending_reg;
            pending_valid_reg <= 1'b0;
        end else if (load_valid && !pending_valid_reg) begin
            pending_reg       <= load_data;
            pending_valid_reg <= 1'b1;
        end
    end

    // Registered drive to the display pins, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n      <= SEG_BLANK;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_next;
            an_n       <= an_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a position-based reference model pushes
// the expected pin state for every clock edge; a monitor compares each one.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int FR = N * R;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           blank_lz;
    logic           load_valid;
    logic           load_ready;
    logic [4*N-1:0] load_data;
    logic [6:0]     seg_n;
    logic [N-1:0]   an_n;
    logic           frame_done;

    typedef struct packed {
        logic [6:0]   seg;
        logic [N-1:0] an;
        logic         fd;
        logic         rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: scan position within a frame, buffers.
    bit             m_active = 0;
    int             m_p      = 0;
    logic [4*N-1:0] m_disp   = '0;
    logic [4*N-1:0] m_pend   = '0;
    bit             m_pv     = 0;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Digits above the highest nonzero digit are hidden; digit0 never is.
    function automatic logic [N-1:0] lz_hide(input logic [4*N-1:0] w, input logic en);
        int hi = 0;
        logic [N-1:0] m = '0;
        for (int i = 0; i < N; i++) if (w[4*i +: 4] != 4'd0) hi = i;
        for (int i = 0; i < N; i++) m[i] = en && (i > hi);
        return m;
    endfunction

    // Reference model: expected pins after each rising edge.
    initial begin
        exp_t e;
        int slot, off;
        logic [N-1:0] hide;
        forever begin
            @(posedge clk);
            e.seg = 7'h7F; e.an = '1; e.fd = 1'b0;
            if (rst) begin
                m_active = 0; m_p = 0; m_disp = '0; m_pend = '0; m_pv = 0;
            end else begin
                if (enable && m_active) begin
                    slot = m_p / R;
                    off  = m_p % R;
                    hide = lz_hide(m_disp, blank_lz);
                    if (off >= B && !hide[slot]) begin
                        e.an[slot] = 1'b0;
                        e.seg      = SEG_TAB[m_disp[4*slot +: 4]];
                    end
                    e.fd = (m_p == FR - 1);
                end
                if (enable && m_active && m_p == FR - 1 && m_pv) begin
                    m_disp = m_pend; m_pv = 0;
                end else if (load_valid && !m_pv) begin
                    m_pend = load_data; m_pv = 1;
                end
                if (!enable) begin
                    m_active = 0; m_p = 0;
                end else if (!m_active) begin
                    m_active = 1; m_p = 0;
                end else begin
                    m_p = (m_p + 1) % FR;
                end
            end
            e.rdy = !m_pv;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare DUT pins against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (seg_n !== e.seg) begin
                    errors++;
                    $display("FAIL seg_n t=%0t got %b exp %b", $time, seg_n, e.seg);
                end
                checks++;
                if (an_n !== e.an) begin
                    errors++;
                    $display("FAIL an_n t=%0t got %b exp %b", $time, an_n, e.an);
                end
                checks++;
                if (frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL frame_done t=%0t got %b exp %b", $time, frame_done, e.fd);
                end
                checks++;
                if (load_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL load_ready t=%0t got %b exp %b", $time, load_ready, e.rdy);
                end
            end
        end
    end

    // Offer a word and hold it until the DUT takes it (bounded wait).
    task automatic do_load(input logic [4*N-1:0] d);
        bit done = 0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        for (int k = 0; k < 6 * FR && !done; k++) begin
            if (load_ready === 1'b1) begin
                @(posedge clk);
                done = 1;
                $display("load 0x%h accepted t=%0t", d, $time);
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL load_timeout data=0x%h got ready=%b exp ready=1", d, load_ready);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FR) @(negedge clk);
    endtask

    // Wait until the model's scan position reaches pos (driven at negedge).
    task automatic wait_pos(input int pos);
        for (int k = 0; k < 2 * FR && !(m_active && m_p == pos); k++) @(negedge clk);
    endtask

    initial begin
        logic [4*N-1:0] w;
        rst = 1'b1; enable = 1'b0; blank_lz = 1'b0; load_valid = 1'b0; load_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Basic scan of 0x1234.
        enable = 1'b1;
        do_load(16'h1234);
        wait_frames(2);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        do_load(16'h0070);
        wait_frames(2);
        do_load(16'h0000);
        wait_frames(2);
        blank_lz = 1'b0;
        wait_frames(1);

        // Back-to-back loads in the middle of a frame.
        wait_pos(10);
        do_load(16'h1111);
        do_load(16'h2222);
        wait_frames(3);

        // Non-decimal code on digit1.
        do_load(16'h00A9);
        wait_frames(2);

        // Disable during digit2's lit phase, then restart.
        wait_pos(2 * R + 4);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_frames(2);

        // A word loaded while dark waits for a frame.
        enable = 1'b0;
        do_load(16'h5678);
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_frames(2);

        // Randomized words, blanking and short dark periods.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++)
                w[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            do_load(w);
            repeat ($urandom_range(1, 2 * FR)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                enable = 1'b0;
                repeat ($urandom_range(1, 10)) @(negedge clk);
                enable = 1'b1;
            end
        end
        wait_frames(2);

        // Asynchronous reset mid-slot with a word pending.
        blank_lz = 1'b0;
        wait_pos(1);
        do_load(16'h9999);
        wait_pos(R + 4);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (seg_n !== 7'h7F || an_n !== 4'hF || frame_done !== 1'b0 || load_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset got seg=%b an=%b fd=%b rdy=%b exp seg=1111111 an=1111 fd=0 rdy=1",
                     seg_n, an_n, frame_done, load_ready);
        end
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wait_frames(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-segment, multi-digit seven-segment display. Accepts a packed BCD word through a valid/ready handshake and holds it in a pending buffer. Commits the buffer to the display only at frame boundaries, so no frame ever mixes old and new digits. Cycles the anode enables, inserts an anti-ghosting blank gap before each digit, and applies optional leading-zero blanking.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 100000, clk cycles per digit slot (>=4)
BLANK_CYCLES, 16, gap cycles at the start of each slot with everything off; 1 <= BLANK_CYCLES < REFRESH_DIV

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  scanning enabled; 0 = display dark
blank_lz  in  1  leading-zero blanking enable
load_valid  in  1  load_data valid
load_ready  out  1  pending buffer empty
load_data  in  4*NUM_DIGITS  BCD digits; digit0 = [3:0] (least significant)
seg_n  out  7  segments a..g, bit6=a, active-low
an_n  out  NUM_DIGITS  anode enables, active-low, one-hot-or-none
frame_done  out  1  one-cycle pulse at the last cycle of each frame

Behaviour:
- Reset (async, any time, including mid-slot or mid-handshake): seg_n=7'h7F, an_n=all 1s, load_ready=1, frame_done=0, display reg=0, pending cleared, idx=0, cnt=0, state=IDLE.
- FSM states: IDLE, GAP, ON.
  - IDLE: outputs dark; cnt and idx held at 0.
  - IDLE->GAP: the cycle after enable=1.
  - GAP->ON: when cnt==BLANK_CYCLES-1.
  - ON->GAP: when cnt==REFRESH_DIV-1. idx increments, wrapping NUM_DIGITS-1 -> 0.
  - Any state->IDLE: when enable=0. Outputs go dark on the next clk edge.
- cnt runs 0..REFRESH_DIV-1 per slot and resets to 0 on every slot change.
- Output timing: seg_n, an_n and frame_done are registered, one cycle behind the state/cnt that produce them.
  - GAP: an_n all 1s, seg_n 7'h7F.
  - ON: an_n[idx]=0, seg_n=decode(display digit idx).
- Decode (0..9, active-low a..g):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100,
  5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  Codes 10..15 decode blank (1111111) and the anode still asserts.
- Leading-zero blanking (blank_lz=1): scanning from digit NUM_DIGITS-1 downward, every digit equal to 0 that sits above the first nonzero digit is suppressed. Digit0 is never suppressed. A suppressed digit keeps an_n all 1s for its entire slot. blank_lz is sampled combinationally each cycle.
- Load handshake:
  - Transfer occurs when load_valid && load_ready. data goes to pending; pending_valid=1; load_ready=0 from the next cycle.
  - load_ready = !pending_valid.
- Commit: at the last cycle of digit NUM_DIGITS-1's ON phase, same cycle frame_done is generated.
  - If pending_valid: display<=pending and pending_valid<=0.
  - A transfer in that same cycle is impossible (ready=0 while pending). A transfer in the cycle after commit waits for the next frame.
- While enable=0 there are no frames. A pending word waits; load_ready stays 0 until a frame completes.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. frame_done pulses exactly once per frame.

Decomposition:
- Package seg_scan_pkg:
  - typedef enum scan_state_t {IDLE, GAP, ON}
  - SEG_BLANK=7'h7F
  - function bcd_to_seg_n(logic [3:0]) returning logic [6:0], holding the decode table above
- Sub-module seg_lz_mask: combinational. Inputs: display word and blank_lz. Output: NUM_DIGITS-bit suppress mask.
- FSM, counters, handshake and output registers live in the top.

Test Plan:
Use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 throughout.
1. enable=1, load 0x1234, wait one frame -> per slot: 2 cycles dark, then 6 cycles of an_n=1110/seg_n=1001100 (digit0=4); next slots 1101/0000110, 1011/0010010, 0111/1001111; frame_done every 32 cycles.
2. Load 0x0070, blank_lz=1 -> digits 3,2 slots fully dark; 1110/0000001, 1101/0001111. Load 0x0000 -> only digit0 lit with 0000001. blank_lz=0 -> all four lit.
3. Two back-to-back loads 0x1111 then 0x2222 mid-frame -> first accepted; load_ready=0 until frame_done; display switches to 0x1111 only at the frame boundary; 0x2222 is accepted the cycle after commit and shown one frame later; no mixed frame.
4. Load 0x00A9 -> digit0 seg_n=0000100; digit1 anode asserted with seg_n=1111111.
5. enable dropped mid-ON of digit2 -> next edge an_n=1111, seg_n=1111111, no frame_done. Re-enable -> scan restarts at digit0 GAP.
6. Assert rst asynchronously mid-slot with a pending load -> outputs at reset values immediately, without waiting for a clk edge; pending lost; load_ready=1.
